machine_timer: RTL and testbench

//  Memory-mapped machine timer: the interrupt source feeding the core's interrupt arbiter via int_flag.

---
 rtl/machine_timer_pkg.sv | 28 ++
 rtl/machine_timer_presc.sv | 35 +++
 rtl/machine_timer.sv | 167 ++++++++++++++++
 tb/tb_machine_timer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/machine_timer_pkg.sv
// rtl/machine_timer_pkg.sv - shared register map, CTRL bit indices, FSM states and bus constants for machine_timer
package machine_timer_pkg;

  localparam logic [1:0] MTIMER_CTRL  = 2'd0;
  localparam logic [1:0] MTIMER_COUNT = 2'd1;
  localparam logic [1:0] MTIMER_VALUE = 2'd2;
  localparam logic [1:0] MTIMER_PRESC = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_INT_EN   = 1;
  localparam int CTRL_PENDING  = 2;
  localparam int CTRL_PERIODIC = 3;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic INT_ASSERT   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] ctrl_word(input logic periodic, input logic pending,
                                            input logic int_en, input logic enable);
    ctrl_word = {28'd0, periodic, pending, int_en, enable};
  endfunction

endpackage

// File: rtl/machine_timer_presc.sv
// rtl/machine_timer_presc.sv - tick divider for machine_timer, used only with MTIMER_PRESCALER_EN
// Fires tick_o every presc_i+1 cycles while run_i is high; restarts when stopped or cleared.
module machine_timer_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = run_i & (cnt_q == presc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped machine timer with level interrupt and W1C pending bit
// Define MTIMER_PRESCALER_EN to enable the PRESC register and tick divider.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        int_sig_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   value_q, value_d;
  logic               enable_q, enable_d;
  logic               int_en_q, int_en_d;
  logic               pending_q, pending_d;
  logic               periodic_q, periodic_d;
  logic               ack_q;
  logic [31:0]        data_q;
  logic               int_q;
  logic [31:0]        rdata;
  logic [CNT_W:0]     count_inc;
  logic               wr, ctrl_wr, count_wr, value_wr;
  logic               stop_wr;
  logic               tick;
  logic               unused_bits;

  assign wr       = req_i & (we_i == WRITE_ENABLE);
  assign ctrl_wr  = wr & (addr_i[3:2] == MTIMER_CTRL);
  assign count_wr = wr & (addr_i[3:2] == MTIMER_COUNT);
  assign value_wr = wr & (addr_i[3:2] == MTIMER_VALUE);
  assign stop_wr  = ctrl_wr & ~data_i[CTRL_ENABLE];

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

`ifdef MTIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q;
  logic               presc_wr;

  assign presc_wr = wr & (addr_i[3:2] == MTIMER_PRESC);

  machine_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .run_i   (state_q == S_RUN),
    .clr_i   (presc_wr),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (presc_wr) begin
      presc_q <= data_i[PRESC_W-1:0];
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Read data reflects the pre-edge register contents.
  always_comb begin
    rdata = '0;
    unique case (addr_i[3:2])
      MTIMER_CTRL:  rdata = ctrl_word(periodic_q, pending_q, int_en_q, enable_q);
      MTIMER_COUNT: rdata[CNT_W-1:0] = count_q;
      MTIMER_VALUE: rdata[CNT_W-1:0] = value_q;
      default: begin
`ifdef MTIMER_PRESCALER_EN
        rdata[PRESC_W-1:0] = presc_q;
`endif
      end
    endcase
  end

  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

  // Software writes are applied first; a tick's expiry then overrides pending/enable.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    value_d    = value_q;
    enable_d   = enable_q;
    int_en_d   = int_en_q;
    pending_d  = pending_q;
    periodic_d = periodic_q;

    if (ctrl_wr) begin
      enable_d   = data_i[CTRL_ENABLE];
      int_en_d   = data_i[CTRL_INT_EN];
      periodic_d = data_i[CTRL_PERIODIC];
      if (data_i[CTRL_PENDING]) begin
        pending_d = 1'b0;
      end
      if (data_i[CTRL_ENABLE]) begin
        state_d = S_RUN;
      end else if (state_q == S_RUN) begin
        state_d = S_IDLE;
      end
    end
    if (count_wr) begin
      count_d = data_i[CNT_W-1:0];
    end
    if (value_wr) begin
      value_d = data_i[CNT_W-1:0];
    end

    unique case (state_q)
      S_RUN: begin
        if (tick && !count_wr && !stop_wr) begin
          if ((value_q != '0) && (count_inc >= {1'b0, value_q})) begin
            count_d   = '0;
            pending_d = 1'b1;
            if (!periodic_q) begin
              enable_d = 1'b0;
              state_d  = S_DONE;
            end
          end else begin
            count_d = count_inc[CNT_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      value_q    <= '0;
      enable_q   <= 1'b0;
      int_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      periodic_q <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      int_q      <= ~INT_ASSERT;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      value_q    <= value_d;
      enable_q   <= enable_d;
      int_en_q   <= int_en_d;
      pending_q  <= pending_d;
      periodic_q <= periodic_d;
      ack_q      <= req_i;
      data_q     <= req_i ? rdata : '0;
      int_q      <= pending_q & int_en_q;
    end
  end

  assign data_o    = data_q;
  assign ack_o     = ack_q;
  assign int_sig_o = int_q;

endmodule

// File: tb/tb_machine_timer.sv
// tb/tb_machine_timer.sv - scoreboard bench for machine_timer; prescaler expectations follow MTIMER_PRESCALER_EN
module tb_machine_timer;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        int_sig_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sbq[$];

  localparam logic [31:0] A_CTRL  = 32'h0;
  localparam logic [31:0] A_COUNT = 32'h4;
  localparam logic [31:0] A_VALUE = 32'h8;
  localparam logic [31:0] A_PRESC = 32'hC;

`ifdef MTIMER_PRESCALER_EN
  localparam int          EXP_LAT   = 8;
  localparam logic [31:0] EXP_PRESC = 32'h3;
`else
  localparam int          EXP_LAT   = 2;
  localparam logic [31:0] EXP_PRESC = 32'h0;
`endif

  machine_timer dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .int_sig_o (int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge; each access spans one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_read = 1'b0; e.exp = '0; e.nm = "wr";
    sbq.push_back(e);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    exp_t e;
    e.is_read = 1'b1; e.exp = exp; e.nm = nm;
    sbq.push_back(e);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; data_i = 32'h0;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every ack pops one scoreboard entry; reads compare data_o.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack_o=1 with no access outstanding");
        end else begin
          e = sbq.pop_front();
          if (e.is_read) check(e.nm, data_o, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (2) @(negedge clk);
    check("reset_int", {31'd0, int_sig_o}, 32'd0);
    check("reset_ack", {31'd0, ack_o}, 32'd0);
    rst = 1'b0;

    // One-shot: expiry on the 5th tick, interrupt one cycle later
    wr(A_VALUE, 32'd5);
    wr(A_CTRL, 32'h3);
    idle(5);
    check("oneshot_int_lag", {31'd0, int_sig_o}, 32'd0);
    idle(1);
    check("oneshot_int", {31'd0, int_sig_o}, 32'd1);
    rd(A_CTRL, 32'h6, "oneshot_ctrl");
    rd(A_COUNT, 32'h0, "oneshot_count");
    idle(2);
    rd(A_COUNT, 32'h0, "oneshot_count_held");
    wr(A_CTRL, 32'h4);
    check("w1c_int_still", {31'd0, int_sig_o}, 32'd1);
    idle(1);
    check("w1c_int_drop", {31'd0, int_sig_o}, 32'd0);
    rd(A_CTRL, 32'h0, "w1c_ctrl");

    // Periodic every 3 ticks, W1C clears between expiries
    wr(A_VALUE, 32'd3);
    wr(A_CTRL, 32'hB);
    idle(2);
    rd(A_CTRL, 32'hB, "periodic_pre");
    rd(A_CTRL, 32'hF, "periodic_pend");
    wr(A_CTRL, 32'hF);
    check("periodic_int_hi", {31'd0, int_sig_o}, 32'd1);
    idle(1);
    check("periodic_int_drop", {31'd0, int_sig_o}, 32'd0);
    rd(A_CTRL, 32'hF, "periodic_again");
    check("periodic_int_again", {31'd0, int_sig_o}, 32'd1);

    // W1C lands on the expiry edge: expiry wins
    idle(1);
    wr(A_CTRL, 32'hF);
    check("race_int0", {31'd0, int_sig_o}, 32'd1);
    rd(A_CTRL, 32'hF, "race_ctrl");
    check("race_int1", {31'd0, int_sig_o}, 32'd1);

    // Bus timing, COUNT write vs tick, VALUE below COUNT
    wr(A_CTRL, 32'h4);
    rd(A_COUNT, 32'h1, "stop_count");
    wr(A_VALUE, 32'h0);
    wr(A_CTRL, 32'h1);
    idle(2);
    rd(A_COUNT, 32'h3, "run_count");
    wr(A_COUNT, 32'h10);
    rd(A_COUNT, 32'h10, "count_wr");
    rd(A_COUNT, 32'h11, "count_wr_tick");
    wr(A_VALUE, 32'h5);
    idle(1);
    rd(A_CTRL, 32'h4, "below_ctrl");
    rd(A_COUNT, 32'h0, "below_count");
    check("masked_int", {31'd0, int_sig_o}, 32'd0);

    // Counter wrap with VALUE==0
    wr(A_VALUE, 32'h0);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    rd(A_COUNT, 32'hFFFF_FFFF, "wrap_pre");
    rd(A_COUNT, 32'h0, "wrap_post");

    // Prescaler
    wr(A_CTRL, 32'h4);
    wr(A_COUNT, 32'h0);
    wr(A_VALUE, 32'd2);
    wr(A_PRESC, 32'd3);
    rd(A_PRESC, EXP_PRESC, "presc_rd");
    wr(A_CTRL, 32'h3);
    idle(EXP_LAT - 1);
    rd(A_CTRL, 32'h3, "presc_pre");
    rd(A_CTRL, 32'h6, "presc_expire");
    check("presc_int", {31'd0, int_sig_o}, 32'd1);

    // Reset mid-run with a read in flight
    wr(A_CTRL, 32'hB);
    idle(3);
    rst = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = A_COUNT;
    @(negedge clk);
    req_i = 1'b0;
    check("rst_ack_drop", {31'd0, ack_o}, 32'd0);
    check("rst_int_drop", {31'd0, int_sig_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_COUNT, 32'h0, "rst_count");
    rd(A_VALUE, 32'h0, "rst_value");
    rd(A_PRESC, 32'h0, "rst_presc");
    rd(A_COUNT, 32'h0, "rst_count_idle");
    idle(2);
    check("sb_drain", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
